led_band_scan_controller: RTL and testbench

- Next-generation LED band output engine for NB_BANDS parallel LED driver chains.
- Generates its own SCLK/LAT.
- Sequences row/colour/bit-plane internally from a single angle_start pulse.
- Serialises grayscale data read from an external double-buffered band memory and manages the buffer swap at safe frame boundaries.
- Sits between the band memories, which the write path fills, and the driver chain pins.

---
 rtl/led_band_scan_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_led_band_scan_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_band_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : led_band_scan_controller
// Purpose  : Per-angle LED band scan engine: fetches grayscale words from a
//            double-buffered band memory, shifts them to NB_BANDS driver chains
//            with its own SCLK/LAT, and swaps the writer bank at idle points.
//            Optional macro LED_BAND_TEST_PATTERN_EN adds a test_en input.
// Revision : 1.0  initial release
// ============================================================================
module led_band_scan_controller #(
  parameter int NB_BANDS       = 2,
  parameter int NB_LED_COLUMN  = 32,
  parameter int BIT_PER_COLOR  = 8,
  parameter int NB_0_LSB       = 1,
  parameter int NB_ANGLES      = 128,
  parameter int SCLK_HALF      = 2,
  parameter int GS_LAT_PERIODS = 3
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  angle_start,
  input  logic [$clog2(NB_ANGLES)-1:0]                          angle,
  input  logic                                                  new_frame,
`ifdef LED_BAND_TEST_PATTERN_EN
  input  logic                                                  test_en,
`endif
  output logic                                                  w_bank,
  output logic                                                  r_en,
  output logic [$clog2(NB_ANGLES)+$clog2(NB_LED_COLUMN)+2:0]    r_addr,
  input  logic [NB_BANDS*BIT_PER_COLOR-1:0]                     r_data,
  output logic                                                  SCLK,
  output logic                                                  LAT,
  output logic [NB_BANDS-1:0]                                   SOUT,
  output logic                                                  busy,
  output logic                                                  frame_swapped,
  output logic                                                  overrun,
  output logic [7:0]                                            overrun_cnt
);

  localparam int C_WORD_W   = BIT_PER_COLOR + NB_0_LSB;
  localparam int C_CNT_W    = $clog2(GS_LAT_PERIODS*2*SCLK_HALF + 1);
  localparam int C_BC_W     = (C_WORD_W > 1) ? $clog2(C_WORD_W) : 1;
  localparam int C_ROW_W    = $clog2(NB_LED_COLUMN);
  localparam int C_ANG_W    = $clog2(NB_ANGLES);

  localparam logic [C_CNT_W-1:0] C_HALF      = C_CNT_W'(SCLK_HALF);
  localparam logic [C_CNT_W-1:0] C_BIT_LAST  = C_CNT_W'(2*SCLK_HALF - 1);
  localparam logic [C_CNT_W-1:0] C_LAT_SHORT = C_CNT_W'(2*SCLK_HALF - 1);
  localparam logic [C_CNT_W-1:0] C_LAT_LONG  = C_CNT_W'(GS_LAT_PERIODS*2*SCLK_HALF - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
  localparam logic [C_BC_W-1:0]  C_BIT_INIT  = C_BC_W'(C_WORD_W - 1);
  localparam logic [C_BC_W-1:0]  C_BC_ONE    = C_BC_W'(1);
  localparam logic [C_ROW_W-1:0] C_ROW_LAST  = C_ROW_W'(NB_LED_COLUMN - 1);
  localparam logic [C_ROW_W-1:0] C_ROW_ONE   = C_ROW_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_SHIFT   = 3'd3,
    S_LATCH   = 3'd4
  } state_t;

  state_t               r_state, w_state_nx;
  logic [C_CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [C_BC_W-1:0]    r_bit, w_bit_nx;
  logic [C_ROW_W-1:0]   r_row, w_row_nx;
  logic [1:0]           r_color, w_color_nx;
  logic [C_ANG_W-1:0]   r_angle;
  logic                 w_start, w_load, w_shift, w_swap;
  logic                 w_test, w_test_nx;
  logic                 r_sclk, r_lat, r_rd_en, r_bank, r_pending, r_swapped;
  logic                 r_overrun;
  logic [7:0]           r_ovr_cnt;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_row_nx   = r_row;
    w_color_nx = r_color;
    w_start    = 1'b0;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (angle_start) begin
          w_start    = 1'b1;
          w_row_nx   = C_ROW_LAST;
          w_color_nx = 2'd2;
          w_cnt_nx   = '0;
          w_state_nx = S_FETCH;
        end
      end
      S_FETCH: w_state_nx = S_CAPTURE;
      S_CAPTURE: begin
        w_load     = 1'b1;
        w_bit_nx   = C_BIT_INIT;
        w_cnt_nx   = '0;
        w_state_nx = S_SHIFT;
      end
      S_SHIFT: begin
        // One bit spans SCLK_HALF low clks then SCLK_HALF high clks; data
        // advances on the edge where SCLK returns low.
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_nx = '0;
          w_shift  = 1'b1;
          if (r_bit == '0) begin
            if (r_color != 2'd0) begin
              w_color_nx = r_color - 2'd1;
              w_state_nx = S_FETCH;
            end else begin
              w_state_nx = S_LATCH;
            end
          end else begin
            w_bit_nx = r_bit - C_BC_ONE;
          end
        end else begin
          w_cnt_nx = r_cnt + C_CNT_ONE;
        end
      end
      S_LATCH: begin
        if (r_cnt == ((r_row != '0) ? C_LAT_SHORT : C_LAT_LONG)) begin
          w_cnt_nx = '0;
          if (r_row != '0) begin
            w_row_nx   = r_row - C_ROW_ONE;
            w_color_nx = 2'd2;
            w_state_nx = S_FETCH;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_cnt_nx = r_cnt + C_CNT_ONE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_row   <= '0;
      r_color <= 2'd0;
      r_angle <= '0;
      r_sclk  <= 1'b0;
      r_lat   <= 1'b0;
      r_rd_en <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_row   <= w_row_nx;
      r_color <= w_color_nx;
      if (w_start) r_angle <= angle;
      r_sclk  <= (w_state_nx == S_SHIFT) && (w_cnt_nx >= C_HALF);
      r_lat   <= (w_state_nx == S_LATCH);
      r_rd_en <= (w_state_nx == S_FETCH) && !w_test_nx;
    end
  end

`ifdef LED_BAND_TEST_PATTERN_EN
  logic r_test;
  assign w_test_nx = w_start ? test_en : r_test;
  assign w_test    = r_test;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_test <= 1'b0;
    else        r_test <= w_test_nx;
  end
`else
  assign w_test_nx = 1'b0;
  assign w_test    = 1'b0;
`endif

  // A swap is only taken while idle so a scan never sees its bank change.
  assign w_swap = (r_state == S_IDLE) && (r_pending || new_frame);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank    <= 1'b0;
      r_pending <= 1'b0;
      r_swapped <= 1'b0;
      r_overrun <= 1'b0;
      r_ovr_cnt <= 8'd0;
    end else begin
      r_pending <= w_swap ? 1'b0 : (r_pending | new_frame);
      r_swapped <= w_swap;
      if (w_swap) r_bank <= ~r_bank;
      r_overrun <= angle_start && (r_state != S_IDLE);
      if (angle_start && (r_state != S_IDLE) && (r_ovr_cnt != 8'hFF))
        r_ovr_cnt <= r_ovr_cnt + 8'd1;
    end
  end

  for (genvar b = 0; b < NB_BANDS; b++) begin : g_band
    logic [C_WORD_W-1:0] r_shreg;
    logic [C_WORD_W-1:0] w_word;
    always_comb begin
      w_word = '0;
      w_word[C_WORD_W-1 -: BIT_PER_COLOR] =
        w_test ? {BIT_PER_COLOR{1'b1}} : r_data[b*BIT_PER_COLOR +: BIT_PER_COLOR];
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_shreg <= '0;
      else if (w_load)  r_shreg <= w_word;
      else if (w_shift) r_shreg <= r_shreg << 1;
    end
    assign SOUT[b] = r_shreg[C_WORD_W-1];
  end

  assign w_bank        = r_bank;
  assign r_en          = r_rd_en;
  assign r_addr        = {~r_bank, r_angle, r_row, r_color};
  assign SCLK          = r_sclk;
  assign LAT           = r_lat;
  assign busy          = (r_state != S_IDLE);
  assign frame_swapped = r_swapped;
  assign overrun       = r_overrun;
  assign overrun_cnt   = r_ovr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_led_band_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_band_scan_controller
// Purpose  : Self-checking bench for led_band_scan_controller (small config).
// Revision : 1.0  initial release
// ============================================================================
module tb_led_band_scan_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       angle_start = 1'b0;
  logic [1:0] angle = 2'd0;
  logic       new_frame = 1'b0;
`ifdef LED_BAND_TEST_PATTERN_EN
  logic       test_en = 1'b0;
`endif
  logic       w_bank, r_en, SCLK, LAT, busy, frame_swapped, overrun;
  logic [5:0] r_addr;
  logic [7:0] r_data = 8'h00;
  logic [1:0] SOUT;
  logic [7:0] overrun_cnt;
  logic [7:0] cur_data = 8'h00;

  always #5 clk = ~clk;

  led_band_scan_controller #(
    .NB_BANDS(2), .NB_LED_COLUMN(2), .BIT_PER_COLOR(4), .NB_0_LSB(1),
    .NB_ANGLES(4), .SCLK_HALF(1), .GS_LAT_PERIODS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .angle_start(angle_start), .angle(angle),
    .new_frame(new_frame),
`ifdef LED_BAND_TEST_PATTERN_EN
    .test_en(test_en),
`endif
    .w_bank(w_bank), .r_en(r_en), .r_addr(r_addr), .r_data(r_data),
    .SCLK(SCLK), .LAT(LAT), .SOUT(SOUT), .busy(busy),
    .frame_swapped(frame_swapped), .overrun(overrun), .overrun_cnt(overrun_cnt)
  );

  // Memory model: word valid only the clk after a read strobe
  always @(posedge clk) r_data <= r_en ? cur_data : 8'h00;

  int  sclk_rises, lat_pulses, ren_cnt, ovr_pulses, swap_pulses, lat_len;
  logic prev_sclk = 1'b0, prev_lat = 1'b0;
  bit  s0_q[$], s1_q[$];
  int  lat_q[$];
  logic [5:0] addr_q[$];

  always @(negedge clk) begin
    if (SCLK && !prev_sclk) begin
      sclk_rises++;
      s0_q.push_back(SOUT[0]);
      s1_q.push_back(SOUT[1]);
    end
    if (LAT) lat_len++;
    else if (prev_lat) begin
      lat_q.push_back(lat_len);
      lat_pulses++;
      lat_len = 0;
    end
    if (r_en) begin
      ren_cnt++;
      addr_q.push_back(r_addr);
    end
    if (overrun) ovr_pulses++;
    if (frame_swapped) swap_pulses++;
    prev_sclk = SCLK;
    prev_lat  = LAT;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic mon_clear();
    sclk_rises = 0; lat_pulses = 0; ren_cnt = 0; ovr_pulses = 0;
    swap_pulses = 0; lat_len = 0;
    s0_q.delete(); s1_q.delete(); lat_q.delete(); addr_q.delete();
  endtask

  task automatic start_scan(input logic [1:0] a, input logic nf);
    @(posedge clk); #1;
    angle = a; angle_start = 1'b1; new_frame = nf;
    @(posedge clk); #1;
    angle_start = 1'b0; new_frame = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done"}, busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  // Each band's bit stream must be nwords copies of the 5-bit word, MSB first
  task automatic check_sout(input string name, input int band, input logic [4:0] w,
                            input int nwords);
    int bad;
    bad = 0;
    if ((band == 0 ? s0_q.size() : s1_q.size()) != nwords*5) bad = 1000;
    else
      for (int i = 0; i < nwords*5; i++)
        if ((band == 0 ? s0_q[i] : s1_q[i]) != w[4 - (i % 5)]) bad++;
    check(name, bad, 0);
  endtask

  typedef struct {
    logic [1:0] angle;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [5:0] addr0;
    logic [4:0] s0;
    logic [4:0] s1;
  } vec_t;

  vec_t vecs[4];
  logic exp_bank;

  initial begin
    vecs[0] = '{2'd1, 4'hA, 4'h5, 6'b101110, 5'b10100, 5'b01010};
    vecs[1] = '{2'd2, 4'hF, 4'h0, 6'b110110, 5'b11110, 5'b00000};
    vecs[2] = '{2'd3, 4'h8, 4'h1, 6'b111110, 5'b10000, 5'b00010};
    vecs[3] = '{2'd0, 4'h6, 4'hC, 6'b100110, 5'b01100, 5'b11000};
    exp_bank = 1'b0;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", busy, 1'b0);
    check("rst_sclk", SCLK, 1'b0);
    check("rst_lat", LAT, 1'b0);
    check("rst_sout", SOUT, 2'b00);
    check("rst_ren", r_en, 1'b0);
    check("rst_wbank", w_bank, 1'b0);
    check("rst_ovrcnt", overrun_cnt, 8'd0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a scan
    cur_data = 8'h5A;
    start_scan(2'd1, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    check("midscan_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_sclk_lat_ren", {SCLK, LAT, r_en}, 3'b000);
    check("arst_sout", SOUT, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[v]) begin
      int bad;
      mon_clear();
      cur_data = {vecs[v].d1, vecs[v].d0};
      start_scan(vecs[v].angle, 1'b0);
      check($sformatf("v%0d_ren_first", v), r_en, 1'b1);
      check($sformatf("v%0d_addr_first", v), r_addr, vecs[v].addr0);
      wait_idle($sformatf("v%0d", v));
      check($sformatf("v%0d_sclk_rises", v), sclk_rises, 30);
      check($sformatf("v%0d_lat_pulses", v), lat_pulses, 2);
      check($sformatf("v%0d_lat_len0", v), (lat_q.size() > 0) ? lat_q[0] : -1, 2);
      check($sformatf("v%0d_lat_len1", v), (lat_q.size() > 1) ? lat_q[1] : -1, 6);
      check($sformatf("v%0d_ren_cnt", v), ren_cnt, 6);
      check_sout($sformatf("v%0d_sout0", v), 0, vecs[v].s0, 6);
      check_sout($sformatf("v%0d_sout1", v), 1, vecs[v].s1, 6);
      bad = (addr_q.size() == 6) ? 0 : 100;
      for (int i = 0; i < 6 && i < addr_q.size(); i++) begin
        logic [5:0] e;
        e = {~exp_bank, vecs[v].angle, 1'(1 - i/3), 2'(2 - i%3)};
        if (addr_q[i] !== e) bad++;
      end
      check($sformatf("v%0d_addr_seq", v), bad, 0);
    end

    // Two new_frame pulses during a scan: one deferred toggle
    mon_clear();
    cur_data = 8'h5A;
    start_scan(2'd0, 1'b0);
    repeat (5) @(posedge clk); #1;
    new_frame = 1'b1;
    @(posedge clk); #1;
    new_frame = 1'b0;
    repeat (20) @(posedge clk); #1;
    new_frame = 1'b1;
    @(posedge clk); #1;
    new_frame = 1'b0;
    check("swap_mid_busy", busy, 1'b1);
    check("swap_mid_bank", w_bank, exp_bank);
    check("swap_mid_pulses", swap_pulses, 0);
    wait_idle("swap");
    exp_bank = ~exp_bank;
    check("swap_bank_after", w_bank, exp_bank);
    check("swap_pulses", swap_pulses, 1);
    begin
      int bad;
      bad = 0;
      foreach (addr_q[i]) if (addr_q[i][5] !== 1'b1) bad++;
      check("swap_read_bank_const", bad, 0);
    end
    repeat (10) @(negedge clk);
    check("swap_no_double", swap_pulses, 1);
    check("swap_bank_hold", w_bank, exp_bank);

    // new_frame and angle_start in the same idle clk
    mon_clear();
    start_scan(2'd2, 1'b1);
    exp_bank = ~exp_bank;
    check("simul_bank", w_bank, exp_bank);
    check("simul_pulse", frame_swapped, 1'b1);
    check("simul_ren", r_en, 1'b1);
    check("simul_addr", r_addr, {~exp_bank, 2'd2, 1'b1, 2'd2});
    wait_idle("simul");
    check("simul_pulses", swap_pulses, 1);

    // Dropped angle_start pulses
    mon_clear();
    start_scan(2'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(posedge clk); #1;
      angle_start = 1'b1;
      @(posedge clk); #1;
      angle_start = 1'b0;
    end
    wait_idle("ovr");
    check("ovr_pulses", ovr_pulses, 3);
    check("ovr_cnt", overrun_cnt, 8'd3);
    check("ovr_scan_intact", lat_pulses, 2);

    // Hold angle_start high long enough to exceed 255 drops
    @(posedge clk); #1;
    angle_start = 1'b1;
    repeat (400) @(posedge clk); #1;
    angle_start = 1'b0;
    wait_idle("sat");
    check("ovr_saturate", overrun_cnt, 8'd255);

`ifdef LED_BAND_TEST_PATTERN_EN
    mon_clear();
    cur_data = 8'h00;
    test_en = 1'b1;
    start_scan(2'd1, 1'b0);
    test_en = 1'b0;
    check("tp_ren_first", r_en, 1'b0);
    wait_idle("tp");
    check("tp_ren_cnt", ren_cnt, 0);
    check("tp_sclk_rises", sclk_rises, 30);
    check_sout("tp_sout0", 0, 5'b11110, 6);
    check_sout("tp_sout1", 1, 5'b11110, 6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
